// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction-fetch front end.
// Branch-unit select codes, fetch FSM states and the canonical nop word.
package fetch_pkg;

  localparam logic [1:0] PC_SEL_ALU = 2'b00;
  localparam logic [1:0] PC_SEL_IMM = 2'b01;
  localparam logic [1:0] PC_SEL_SEQ = 2'b11;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  localparam logic [31:0] INST_NOP = 32'h0000_0013;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO with occupancy count and synchronous clear.
// Serves both as the decode instruction queue and the in-flight PC tracker.
module fetch_queue #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rptr_q, wptr_q;
  logic [CW-1:0]    count_q;
  logic             full, empty, do_push, do_pop;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = i_pop && !empty;
  // A pop frees the slot in the same cycle, so a full queue may still accept.
  assign do_push = i_push && (!full || do_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else if (i_clr) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      assert (!(i_push && full && !i_pop));
      if (do_push) wptr_q <= next_ptr(wptr_q);
      if (do_pop)  rptr_q <= next_ptr(rptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push && !i_clr) mem_q[wptr_q] <= i_wdata;
  end

  assign o_rdata = mem_q[rptr_q];
  assign o_count = count_q;

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch front end: owns the fetch PC, issues in-order imem requests under a
// credit limit, queues returned words for decode and squashes stale responses.
//
//  state | meaning
//  BOOT  | first cycle after reset, no requests
//  RUN   | sequential fetch, redirects accepted
//  HALT  | misaligned redirect seen; idle until reset
module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_ADDR = '0,
  parameter int              QDEPTH     = 2
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_redirect_valid,
  input  logic [1:0]      i_pc_sel,
  input  logic [XLEN-1:0] i_ex_pc,
  input  logic [XLEN-1:0] i_imm,
  input  logic [XLEN-1:0] i_alu_result,
  output logic            o_imem_req_valid,
  input  logic            i_imem_req_ready,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_rsp_valid,
  input  logic [31:0]     i_imem_rsp_data,
  output logic            o_if_valid,
  input  logic            i_if_ready,
  output logic [XLEN-1:0] o_if_pc,
  output logic [31:0]     o_if_inst,
  output logic            o_flush,
  output logic            o_misaligned
);

  localparam int CW = $clog2(QDEPTH + 1);
  localparam int QW = XLEN + 32;

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   drop_q, drop_d;

  logic [CW-1:0]   q_count, pcf_count;
  logic [QW-1:0]   q_head;
  logic [XLEN-1:0] pcf_head;
  logic [XLEN-1:0] target;
  logic            redirect, q_valid, pop, credit_ok, req_valid, accept;
  logic            rsp_drop, q_push, q_clr;

  assign redirect = (state_q == RUN) && i_redirect_valid && (i_pc_sel != PC_SEL_SEQ);
  assign target   = (i_pc_sel == PC_SEL_IMM) ? (i_ex_pc + i_imm)
                                             : {i_alu_result[XLEN-1:1], 1'b0};

  assign q_valid   = (q_count != '0);
  assign pop       = q_valid && i_if_ready;
  // Every in-flight request must already own a queue slot when it returns.
  assign credit_ok = (int'(pcf_count) + int'(q_count) - int'(pop)) < QDEPTH;
  assign req_valid = (state_q == RUN) && !redirect && credit_ok;
  assign accept    = req_valid && i_imem_req_ready;

  assign rsp_drop = i_imem_rsp_valid && (drop_q != '0);
  assign q_push   = i_imem_rsp_valid && !rsp_drop && (state_q == RUN);
  assign q_clr    = redirect || (state_q == HALT);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= BOOT;
      fetch_pc_q <= RESET_ADDR;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      drop_q     <= drop_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    drop_d     = drop_q;
    if (rsp_drop) drop_d = drop_q - CW'(1);
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (redirect) begin
          fetch_pc_d = target;
          // Everything still in flight belongs to the squashed path.
          drop_d     = pcf_count - CW'(i_imem_rsp_valid);
          if (target[1]) state_d = HALT;
        end else if (accept) begin
          fetch_pc_d = fetch_pc_q + XLEN'(4);
        end
      end
      HALT:    state_d = HALT;
      default: state_d = BOOT;
    endcase
  end

  fetch_queue #(
    .WIDTH (QW),
    .DEPTH (QDEPTH)
  ) u_inst_q (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (q_clr),
    .i_push  (q_push),
    .i_wdata ({pcf_head, i_imem_rsp_data}),
    .i_pop   (pop),
    .o_rdata (q_head),
    .o_count (q_count)
  );

  fetch_queue #(
    .WIDTH (XLEN),
    .DEPTH (QDEPTH)
  ) u_pc_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (1'b0),
    .i_push  (accept),
    .i_wdata (fetch_pc_q),
    .i_pop   (i_imem_rsp_valid),
    .o_rdata (pcf_head),
    .o_count (pcf_count)
  );

  assign o_imem_req_valid = req_valid;
  assign o_imem_addr      = fetch_pc_q;
  assign o_flush          = redirect;
  assign o_misaligned     = (state_q == HALT);
  assign o_if_valid       = q_valid;
  assign o_if_pc          = q_valid ? q_head[QW-1:32] : '0;
  assign o_if_inst        = q_valid ? q_head[31:0] : '0;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Randomized bench for fetch_pc_unit against a queue-based reference model,
// with directed scenarios for boot latency, stalls, redirects, halt and wrap.
module tb_fetch_pc_unit;
  import fetch_pkg::*;

  localparam int          XLEN       = 32;
  localparam int          QDEPTH     = 2;
  localparam logic [31:0] RESET_ADDR = 32'h0000_0000;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_redirect_valid = 1'b0;
  logic [1:0]  i_pc_sel = 2'b11;
  logic [31:0] i_ex_pc = '0, i_imm = '0, i_alu_result = '0;
  logic        o_imem_req_valid;
  logic        i_imem_req_ready = 1'b0;
  logic [31:0] o_imem_addr;
  logic        i_imem_rsp_valid = 1'b0;
  logic [31:0] i_imem_rsp_data = '0;
  logic        o_if_valid;
  logic        i_if_ready = 1'b0;
  logic [31:0] o_if_pc, o_if_inst;
  logic        o_flush, o_misaligned;

  fetch_pc_unit #(.XLEN(XLEN), .RESET_ADDR(RESET_ADDR), .QDEPTH(QDEPTH)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_redirect_valid(i_redirect_valid), .i_pc_sel(i_pc_sel),
    .i_ex_pc(i_ex_pc), .i_imm(i_imm), .i_alu_result(i_alu_result),
    .o_imem_req_valid(o_imem_req_valid), .i_imem_req_ready(i_imem_req_ready),
    .o_imem_addr(o_imem_addr),
    .i_imem_rsp_valid(i_imem_rsp_valid), .i_imem_rsp_data(i_imem_rsp_data),
    .o_if_valid(o_if_valid), .i_if_ready(i_if_ready),
    .o_if_pc(o_if_pc), .o_if_inst(o_if_inst),
    .o_flush(o_flush), .o_misaligned(o_misaligned)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model: 0 boot, 1 run, 2 halt
  int          m_state;
  logic [31:0] m_pc;
  logic [63:0] m_q[$];
  logic [31:0] m_infl[$];
  int          m_drop;
  // Memory model: accepted addresses and earliest response cycle
  logic [31:0] mem_addr[$];
  int          mem_due[$];
  int          cyc;
  int          k_req_rdy, k_if_rdy, k_rsp, k_lat_min, k_lat_max;
  // Last sampled DUT outputs for directed checks
  logic        last_ifv, last_req, last_flush, last_mis;
  logic [31:0] last_pc, last_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a[4:2] == 3'd7) return INST_NOP;
    return {a[15:0] ^ 16'hC3A5, a[31:16]};
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_pc    = RESET_ADDR;
    m_q.delete();
    m_infl.delete();
    m_drop  = 0;
    mem_addr.delete();
    mem_due.delete();
    cyc     = 0;
  endtask

  task automatic step(input logic rv, input logic [1:0] sel, input logic [31:0] ex,
                      input logic [31:0] imm, input logic [31:0] alu);
    logic        redir, pop, req_exp, accept, rsp;
    logic [31:0] tgt, rpc;
    int          st0;
    @(negedge i_clk);
    i_redirect_valid = rv;
    i_pc_sel         = sel;
    i_ex_pc          = ex;
    i_imm            = imm;
    i_alu_result     = alu;
    i_imem_req_ready = ($urandom_range(99) < k_req_rdy);
    i_if_ready       = ($urandom_range(99) < k_if_rdy);
    if (mem_addr.size() > 0 && cyc >= mem_due[0] && $urandom_range(99) < k_rsp) begin
      i_imem_rsp_valid = 1'b1;
      i_imem_rsp_data  = mem_word(mem_addr[0]);
    end else begin
      i_imem_rsp_valid = 1'b0;
      i_imem_rsp_data  = $urandom;
    end
    #1;
    st0     = m_state;
    redir   = (st0 == 1) && rv && (sel != PC_SEL_SEQ);
    pop     = (m_q.size() > 0) && i_if_ready;
    req_exp = (st0 == 1) && !redir && ((m_infl.size() + m_q.size() - int'(pop)) < QDEPTH);
    tgt     = (sel == PC_SEL_IMM) ? ex + imm : {alu[31:1], 1'b0};
    chk("flush", o_flush, redir);
    chk("req_valid", o_imem_req_valid, req_exp);
    chk("imem_addr", o_imem_addr, m_pc);
    chk("if_valid", o_if_valid, m_q.size() > 0);
    if (m_q.size() > 0) chk("if_head", {o_if_pc, o_if_inst}, m_q[0]);
    chk("misaligned", o_misaligned, st0 == 2);
    last_ifv = o_if_valid; last_req = o_imem_req_valid; last_flush = o_flush;
    last_mis = o_misaligned; last_pc = o_if_pc; last_addr = o_imem_addr;
    @(posedge i_clk);
    accept = req_exp && i_imem_req_ready;
    rsp    = i_imem_rsp_valid;
    if (pop && !redir) void'(m_q.pop_front());
    if (rsp && m_infl.size() > 0) begin
      rpc = m_infl.pop_front();
      void'(mem_addr.pop_front());
      void'(mem_due.pop_front());
      if (m_drop > 0) m_drop--;
      else if (st0 == 1 && !redir) m_q.push_back({rpc, i_imem_rsp_data});
    end
    if (accept) begin
      m_infl.push_back(m_pc);
      mem_addr.push_back(m_pc);
      mem_due.push_back(cyc + int'($urandom_range(k_lat_max, k_lat_min)));
      m_pc = m_pc + 32'd4;
    end
    if (redir) begin
      m_pc   = tgt;
      m_q.delete();
      m_drop = m_infl.size();
      if (tgt[1]) m_state = 2;
    end
    if (st0 == 0) m_state = 1;
    if (m_state == 2) m_q.delete();
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, PC_SEL_SEQ, '0, '0, '0);
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_redirect_valid = 1'b0; i_imem_req_ready = 1'b0; i_imem_rsp_valid = 1'b0;
    i_if_ready = 1'b0;
    #2 i_rst_n = 1'b0;
    #1;
    chk("rst_req_valid", o_imem_req_valid, 1'b0);
    chk("rst_addr", o_imem_addr, RESET_ADDR);
    chk("rst_if_valid", o_if_valid, 1'b0);
    chk("rst_if_pc", o_if_pc, 32'h0);
    chk("rst_if_inst", o_if_inst, 32'h0);
    chk("rst_flush", o_flush, 1'b0);
    chk("rst_misaligned", o_misaligned, 1'b0);
    model_reset();
    @(posedge i_clk);
    #2 i_rst_n = 1'b1;
  endtask

  task automatic set_knobs(input int rr, input int ir, input int rp, input int lmin, input int lmax);
    k_req_rdy = rr; k_if_rdy = ir; k_rsp = rp; k_lat_min = lmin; k_lat_max = lmax;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first, n;
    logic [31:0] a, e, im;
    logic [1:0]  s;
    set_knobs(100, 100, 100, 1, 1);
    model_reset();

    // Boot latency and sequential stream
    do_reset();
    first = -1;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, PC_SEL_SEQ, '0, '0, '0);
      if (first < 0 && last_ifv) first = i;
    end
    chk("first_if_valid_cycle", first, 3);

    // Decode stall then release
    set_knobs(100, 0, 100, 1, 1);
    idle(10);
    set_knobs(100, 100, 100, 1, 1);
    idle(6);

    // Redirect with two requests in flight
    set_knobs(100, 100, 100, 4, 4);
    n = 0;
    while (m_infl.size() != 2 && n < 20) begin idle(1); n++; end
    chk("inflight_two", m_infl.size(), 2);
    step(1'b1, PC_SEL_IMM, 32'h100, 32'h40, '0);
    chk("redir_flush", last_flush, 1'b1);
    n = 0;
    last_ifv = 1'b0;
    while (!last_ifv && n < 30) begin idle(1); n++; end
    chk("redir_first_pc", last_pc, 32'h140);

    // ALU target clears bit 0; PC+4 select is not a redirect
    set_knobs(100, 100, 100, 1, 1);
    step(1'b1, PC_SEL_ALU, '0, '0, 32'h2001);
    idle(1);
    chk("alu_target_addr", last_addr, 32'h2000);
    step(1'b1, PC_SEL_SEQ, 32'h500, 32'h8, 32'h3000);
    chk("seq_no_flush", last_flush, 1'b0);
    idle(5);

    // PC wraps past the top of the address space
    step(1'b1, PC_SEL_ALU, '0, '0, 32'hFFFF_FFFC);
    idle(1);
    chk("wrap_start_addr", last_addr, 32'hFFFF_FFFC);
    idle(1);
    chk("wrap_next_addr", last_addr, 32'h0000_0000);
    idle(6);

    // Misaligned redirect halts fetch
    step(1'b1, PC_SEL_ALU, '0, '0, 32'h1002);
    idle(5);
    chk("halt_misaligned", last_mis, 1'b1);
    chk("halt_no_req", last_req, 1'b0);

    // Random segments, each started by a mid-run reset
    for (int seg = 0; seg < 30; seg++) begin
      do_reset();
      set_knobs($urandom_range(100, 30), $urandom_range(100, 20), $urandom_range(100, 40),
                1, $urandom_range(4, 1));
      for (int i = 0; i < 60; i++) begin
        if ($urandom_range(99) < 8) begin
          s  = 2'($urandom_range(2));
          a  = $urandom;
          e  = $urandom & 32'hFFFF_FFFC;
          im = ($urandom_range(99) < 10) ? 32'h2 : ($urandom & 32'h0000_FFFC);
          if ($urandom_range(99) >= 10) a = a & 32'hFFFF_FFFC;
          step(1'b1, s, e, im, a);
        end else begin
          step($urandom_range(1), PC_SEL_SEQ, $urandom, $urandom, $urandom);
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
